// File: rtl/ipg_slot_arbiter.sv
// rtl/ipg_slot_arbiter.sv - per-block slot scheduler for the IPG transmit path
// Picks NET / REQ / MEM / IDLE each 66b slot, pops the FIFOs and paces the MAC.
module ipg_slot_arbiter #(
    parameter int NETQ_SPACE_W = 6,
    parameter int PAUSE_ON     = 4,
    parameter int PAUSE_OFF    = 12,
    parameter int MAX_IPG_RUN  = 8,
    parameter int REQ_WEIGHT   = 2,
    parameter int MEM_WEIGHT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    netq_empty,
    input  logic [NETQ_SPACE_W-1:0] netq_space,
    input  logic [1:0]              netq_head_hdr,
    input  logic [7:0]              netq_head_type,
    input  logic                    reqq_empty,
    input  logic                    memq_empty,
    output logic                    netq_read,
    output logic                    reqq_read,
    output logic                    memq_read,
    output logic [1:0]              sel,
    output logic                    tx_pause,
    output logic                    q_reset,
    output logic                    in_frame,
    output logic                    underrun_err
);
    localparam int MAXW  = (REQ_WEIGHT > MEM_WEIGHT) ? REQ_WEIGHT : MEM_WEIGHT;
    localparam int GNT_W = $clog2(MAXW + 1);
    localparam int RUN_W = $clog2(MAX_IPG_RUN + 1);

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_REQ  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_NET  = 2'b11;

    typedef enum logic {GAP = 1'b0, FRAME = 1'b1} state_t;

    state_t             state, state_next;
    logic               owner, owner_next;          // 0: reqq owns the WRR turn, 1: memq
    logic [GNT_W-1:0]   grant_cnt, grant_cnt_next;
    logic [RUN_W-1:0]   run_cnt, run_cnt_next;
    logic               q_hold;

    logic hdr_ctl, is_idle, is_start, is_term;
    logic ipg_pend, force_net, ipg_go;
    logic owner_ready, other_ready, keep_owner, grant_mem;
    logic [GNT_W-1:0] owner_weight;

    assign hdr_ctl  = !netq_empty && (netq_head_hdr == 2'b01);
    assign is_idle  = hdr_ctl && (netq_head_type == 8'h1e);
    assign is_start = hdr_ctl && (netq_head_type == 8'h78);
    assign is_term  = hdr_ctl && (netq_head_type inside
                      {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff});

    assign ipg_pend  = !reqq_empty || !memq_empty;
    assign force_net = tx_pause || (run_cnt >= RUN_W'(MAX_IPG_RUN));
    assign ipg_go    = (state == GAP) && ipg_pend && (netq_empty || is_idle || !force_net);

    // Weighted round-robin: stay with the owner until its weight is used up,
    // hand over only if the other queue has something to send.
    assign owner_ready  = owner ? !memq_empty : !reqq_empty;
    assign other_ready  = owner ? !reqq_empty : !memq_empty;
    assign owner_weight = owner ? GNT_W'(MEM_WEIGHT) : GNT_W'(REQ_WEIGHT);
    assign keep_owner   = owner_ready && (grant_cnt < owner_weight);
    assign grant_mem    = (keep_owner || !other_ready) ? owner : !owner;

    assign in_frame = (state == FRAME);
    assign q_reset  = reset || q_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= GAP;
            owner        <= 1'b0;
            grant_cnt    <= '0;
            run_cnt      <= '0;
            tx_pause     <= 1'b0;
            underrun_err <= 1'b0;
            q_hold       <= 1'b1;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            grant_cnt <= grant_cnt_next;
            run_cnt   <= run_cnt_next;
            q_hold    <= 1'b0;
            if (netq_space <= NETQ_SPACE_W'(PAUSE_ON))
                tx_pause <= 1'b1;
            else if (netq_space >= NETQ_SPACE_W'(PAUSE_OFF))
                tx_pause <= 1'b0;
            if ((state == FRAME) && netq_empty)
                underrun_err <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        grant_cnt_next = grant_cnt;
        run_cnt_next   = run_cnt;
        case (state)
            FRAME: begin
                if (is_term)
                    state_next = GAP;
            end
            default: begin
                if (ipg_go) begin
                    owner_next     = grant_mem;
                    grant_cnt_next = keep_owner ? grant_cnt + GNT_W'(1) : GNT_W'(1);
                    // Count only slots stolen from a waiting frame start.
                    if (is_start)
                        run_cnt_next = (run_cnt >= RUN_W'(MAX_IPG_RUN)) ? run_cnt
                                                                          : run_cnt + RUN_W'(1);
                    else
                        run_cnt_next = '0;
                end else begin
                    run_cnt_next = '0;
                    if (is_start)
                        state_next = FRAME;
                end
            end
        endcase
    end

    always_comb begin
        sel       = SEL_IDLE;
        netq_read = 1'b0;
        reqq_read = 1'b0;
        memq_read = 1'b0;
        if (!reset) begin
            case (state)
                FRAME: begin
                    if (!netq_empty) begin
                        sel       = SEL_NET;
                        netq_read = 1'b1;
                    end
                end
                default: begin
                    if (ipg_go) begin
                        sel       = grant_mem ? SEL_MEM : SEL_REQ;
                        reqq_read = !grant_mem;
                        memq_read = grant_mem;
                        netq_read = is_idle;
                    end else if (!netq_empty) begin
                        sel       = SEL_NET;
                        netq_read = 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
